// File: rtl/div_shift_sub_pkg.sv
// div_shift_sub_pkg: FSM state type and default width shared by the multiplier/divider family.
package div_shift_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/div_shift_sub_step.sv
// div_step: one restoring-division iteration (shift in dividend bit, compare, conditionally subtract).
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);
  logic [WIDTH+1:0] sh;
  always_comb begin
    sh = {rem, dbit};
    qbit = sh >= (WIDTH+2)'(divisor);
    rem_next = qbit ? (WIDTH+1)'(sh - (WIDTH+2)'(divisor)) : sh[WIDTH:0];
  end
endmodule

// File: rtl/div_shift_sub.sv
// div_shift_sub: sequential restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_FLAG_EN adds a div_zero output and a short path for a zero divisor.
module div_shift_sub
  import div_shift_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dvs;
  logic [WIDTH:0] rem, rem_nx;
  logic qbit, accept, last;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .dbit(dvd[WIDTH-1]),
    .divisor(dvs),
    .rem_next(rem_nx),
    .qbit(qbit)
  );
  always_comb begin
    accept = state == IDLE && start;
    last = state == RUN && cnt == CW'(1);
    state_nx = accept ? RUN : last ? DONE : state == DONE ? IDLE : state;
    busy = state == RUN;
    done = state == DONE;
  end
`ifdef DIV_ZERO_FLAG_EN
  logic dz;
  // A zero divisor spends a single cycle in RUN and then reports the fixed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dz <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      dz <= divisor == '0;
      div_zero <= 1'b0;
    end else if (last) begin
      div_zero <= dz;
    end
  end
`endif
  // dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quotient <= '0;
      remainder <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        dvd <= dividend;
        dvs <= divisor;
        rem <= '0;
`ifdef DIV_ZERO_FLAG_EN
        cnt <= divisor == '0 ? CW'(1) : CW'(WIDTH);
`else
        cnt <= CW'(WIDTH);
`endif
      end else if (state == RUN) begin
        dvd <= {dvd[WIDTH-2:0], qbit};
        rem <= rem_nx;
        cnt <= cnt - 1'b1;
      end
      if (last) begin
`ifdef DIV_ZERO_FLAG_EN
        quotient <= dz ? '1 : {dvd[WIDTH-2:0], qbit};
        remainder <= dz ? dvd : rem_nx[WIDTH-1:0];
`else
        quotient <= {dvd[WIDTH-2:0], qbit};
        remainder <= rem_nx[WIDTH-1:0];
`endif
      end
    end
  end
endmodule
